// File: rtl/kbd_scan_if.sv
// Keyboard controller signal bundle: PS/2 byte input, translator handshake,
// CPU register side and interrupt outputs.
interface kbd_scan_if;
  logic [7:0] ps2_data;
  logic       ps2_stb;
  logic       tr_shift;
  logic       tr_e0;
  logic [7:0] tr_code;
  logic [6:0] tr_ascii;
  logic       tr_ar2;
  logic       rd_ack;
  logic       irq_mask;
  logic       irq_ack;
  logic [6:0] key_code;
  logic       key_ar2;
  logic       key_ready;
  logic       key_down;
  logic       overrun;
  logic       irq_req;
  logic [8:0] irq_vec;

  modport slave (
    input  ps2_data, ps2_stb, tr_ascii, tr_ar2, rd_ack, irq_mask, irq_ack,
    output tr_shift, tr_e0, tr_code, key_code, key_ar2, key_ready, key_down,
           overrun, irq_req, irq_vec
  );

  modport master (
    output ps2_data, ps2_stb, tr_ascii, tr_ar2, rd_ack, irq_mask, irq_ack,
    input  tr_shift, tr_e0, tr_code, key_code, key_ar2, key_ready, key_down,
           overrun, irq_req, irq_vec
  );
endinterface

// File: rtl/kbd_scan_ctrl.sv
// PS/2 scancode parser feeding the scancode translator and the BK keyboard register/IRQ model.
// Define KBD_REPEAT_FILTER_EN to drop typematic repeats of the held key before lookup.
//
// state      | meaning
// S_IDLE     | waiting for the first byte of a code
// S_E0       | E0 prefix seen
// S_F0       | F0 (break) prefix seen
// S_E0F0     | E0 F0 prefix seen
// S_E1SKIP   | swallowing the Pause sequence after E1
// S_LOOKUP   | translator result is sampled this cycle; strobes handled as in S_IDLE
module kbd_scan_ctrl #(
  parameter int unsigned E1_SKIP         = 7,
  parameter bit          IGNORE_CODES_EN = 1'b1
) (
  input logic       clk_sys,
  input logic       reset,
  kbd_scan_if.slave kbd
);

  localparam int unsigned CNT_W = $clog2(E1_SKIP + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_E0,
    S_F0,
    S_E0F0,
    S_E1SKIP,
    S_LOOKUP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lshift_q, lshift_d;
  logic             rshift_q, rshift_d;
  logic             tr_shift_q, tr_shift_d;
  logic             tr_e0_q, tr_e0_d;
  logic [7:0]       tr_code_q, tr_code_d;
  logic [6:0]       key_code_q, key_code_d;
  logic             key_ar2_q, key_ar2_d;
  logic             key_ready_q, key_ready_d;
  logic             key_down_q, key_down_d;
  logic             overrun_q, overrun_d;
  logic             irq_req_q, irq_req_d;
  logic [8:0]       held_q, held_d;

  logic             is_make;
  logic             is_break;
  logic             ev_e0;
  logic [8:0]       ev_code;
  logic             is_repeat;

  function automatic logic is_ignored(input logic [7:0] b);
    return b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'hFF};
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lshift_d    = lshift_q;
    rshift_d    = rshift_q;
    tr_e0_d     = tr_e0_q;
    tr_code_d   = tr_code_q;
    key_code_d  = key_code_q;
    key_ar2_d   = key_ar2_q;
    key_ready_d = key_ready_q;
    key_down_d  = key_down_q;
    overrun_d   = overrun_q;
    irq_req_d   = irq_req_q;
    held_d      = held_q;
    is_make     = 1'b0;
    is_break    = 1'b0;
    ev_e0       = 1'b0;
    is_repeat   = 1'b0;

    if (kbd.rd_ack) begin
      key_ready_d = 1'b0;
      overrun_d   = 1'b0;
      irq_req_d   = 1'b0;
    end
    if (kbd.irq_ack || kbd.irq_mask) begin
      irq_req_d = 1'b0;
    end

    // Lookup runs before the strobe decode so a new latch overrides same-cycle clears.
    if (state_q == S_LOOKUP) begin
      state_d = S_IDLE;
      if (kbd.tr_ascii != '0) begin
        key_down_d = 1'b1;
        held_d     = {tr_e0_q, tr_code_q};
        if (!key_ready_q || kbd.rd_ack) begin
          key_code_d  = kbd.tr_ascii;
          key_ar2_d   = kbd.tr_ar2;
          key_ready_d = 1'b1;
          if (!kbd.irq_mask) begin
            irq_req_d = 1'b1;
          end
        end else begin
          overrun_d = 1'b1;
        end
      end
    end

    if (kbd.ps2_stb) begin
      unique case (state_q)
        S_IDLE, S_LOOKUP: begin
          if (IGNORE_CODES_EN && is_ignored(kbd.ps2_data)) begin
            state_d = S_IDLE;
          end else if (kbd.ps2_data == 8'hE0) begin
            state_d = S_E0;
          end else if (kbd.ps2_data == 8'hF0) begin
            state_d = S_F0;
          end else if (kbd.ps2_data == 8'hE1) begin
            state_d = (E1_SKIP == 0) ? S_IDLE : S_E1SKIP;
            cnt_d   = CNT_W'(E1_SKIP);
          end else begin
            is_make = 1'b1;
          end
        end
        S_E0: begin
          if (kbd.ps2_data == 8'hF0) begin
            state_d = S_E0F0;
          end else if (kbd.ps2_data != 8'hE0) begin
            is_make = 1'b1;
            ev_e0   = 1'b1;
          end
        end
        S_F0: begin
          is_break = 1'b1;
        end
        S_E0F0: begin
          is_break = 1'b1;
          ev_e0    = 1'b1;
        end
        S_E1SKIP: begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    ev_code = {ev_e0, kbd.ps2_data};

`ifdef KBD_REPEAT_FILTER_EN
    is_repeat = key_down_d && (ev_code == held_d);
`else
    is_repeat = 1'b0;
`endif

    if (is_make) begin
      state_d = S_IDLE;
      if (ev_code == 9'h012) begin
        lshift_d = 1'b1;
      end else if (ev_code == 9'h059) begin
        rshift_d = 1'b1;
      end else if (ev_code == 9'h112 || is_repeat) begin
        state_d = S_IDLE;
      end else begin
        tr_code_d = kbd.ps2_data;
        tr_e0_d   = ev_e0;
        state_d   = S_LOOKUP;
      end
    end

    if (is_break) begin
      state_d = S_IDLE;
      if (ev_code == 9'h012) begin
        lshift_d = 1'b0;
      end else if (ev_code == 9'h059) begin
        rshift_d = 1'b0;
      end else if (ev_code == held_q) begin
        key_down_d = 1'b0;
      end
    end

    tr_shift_d = lshift_d | rshift_d;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      tr_shift_q  <= 1'b0;
      tr_e0_q     <= 1'b0;
      tr_code_q   <= '0;
      key_code_q  <= '0;
      key_ar2_q   <= 1'b0;
      key_ready_q <= 1'b0;
      key_down_q  <= 1'b0;
      overrun_q   <= 1'b0;
      irq_req_q   <= 1'b0;
      held_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lshift_q    <= lshift_d;
      rshift_q    <= rshift_d;
      tr_shift_q  <= tr_shift_d;
      tr_e0_q     <= tr_e0_d;
      tr_code_q   <= tr_code_d;
      key_code_q  <= key_code_d;
      key_ar2_q   <= key_ar2_d;
      key_ready_q <= key_ready_d;
      key_down_q  <= key_down_d;
      overrun_q   <= overrun_d;
      irq_req_q   <= irq_req_d;
      held_q      <= held_d;
    end
  end

  assign kbd.tr_shift  = tr_shift_q;
  assign kbd.tr_e0     = tr_e0_q;
  assign kbd.tr_code   = tr_code_q;
  assign kbd.key_code  = key_code_q;
  assign kbd.key_ar2   = key_ar2_q;
  assign kbd.key_ready = key_ready_q;
  assign kbd.key_down  = key_down_q;
  assign kbd.overrun   = overrun_q;
  assign kbd.irq_req   = irq_req_q;
  assign kbd.irq_vec   = key_ar2_q ? 9'o274 : 9'o060;

endmodule

// File: tb/tb_kbd_scan_ctrl.sv
// Bench for kbd_scan_ctrl: vector table, hand-timed corner sequences and a
// byte-level reference model driven by random traffic.
module tb_kbd_scan_ctrl;
  logic clk_sys = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

`ifdef KBD_REPEAT_FILTER_EN
  localparam bit REPEAT_FILTER = 1'b1;
`else
  localparam bit REPEAT_FILTER = 1'b0;
`endif

  kbd_scan_if k ();
  kbd_scan_ctrl dut (.clk_sys(clk_sys), .reset(reset), .kbd(k));

  always #5 clk_sys = ~clk_sys;

  // Small translator stand-in: returns {ar2, ascii}.
  function automatic logic [7:0] xlate(input logic [7:0] c, input logic e, input logic sh);
    logic [7:0] r;
    r = 8'h00;
    if (e) begin
      if (c == 8'h71) r = {1'b1, 7'o031};
    end else begin
      case (c)
        8'h1C:   r = sh ? 8'h41 : 8'h61;
        8'h32:   r = sh ? 8'h42 : 8'h62;
        8'h16:   r = sh ? 8'h21 : 8'h31;
        default: r = 8'h00;
      endcase
    end
    return r;
  endfunction

  always_comb {k.tr_ar2, k.tr_ascii} = xlate(k.tr_code, k.tr_e0, k.tr_shift);

  typedef struct {
    int         op;     // 0 byte, 1 rd_ack, 2 irq_ack
    logic [7:0] data;
    logic [6:0] code;
    logic       ar2, ready, down, ovr, irq, shift;
  } vec_t;
  vec_t tv[$];

  task automatic add(input int op, input logic [7:0] d, input logic [6:0] c, input logic a,
                     input logic rdy, input logic dn, input logic ov, input logic iq, input logic sh);
    vec_t v;
    v.op = op; v.data = d; v.code = c; v.ar2 = a; v.ready = rdy;
    v.down = dn; v.ovr = ov; v.irq = iq; v.shift = sh;
    tv.push_back(v);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string t, input logic [6:0] c, input logic a, input logic rdy,
                           input logic dn, input logic ov, input logic iq, input logic sh);
    chk({t, " key_code"},  32'(k.key_code),  32'(c));
    chk({t, " key_ar2"},   32'(k.key_ar2),   32'(a));
    chk({t, " key_ready"}, 32'(k.key_ready), 32'(rdy));
    chk({t, " key_down"},  32'(k.key_down),  32'(dn));
    chk({t, " overrun"},   32'(k.overrun),   32'(ov));
    chk({t, " irq_req"},   32'(k.irq_req),   32'(iq));
    chk({t, " tr_shift"},  32'(k.tr_shift),  32'(sh));
    chk({t, " irq_vec"},   32'(k.irq_vec),   a ? 32'o274 : 32'o060);
  endtask

  task automatic send(input logic [7:0] b);
    k.ps2_data = b; k.ps2_stb = 1'b1;
    cyc(1);
    k.ps2_stb = 1'b0;
    cyc(3);
  endtask

  task automatic pulse_rd();
    k.rd_ack = 1'b1; cyc(1); k.rd_ack = 1'b0; cyc(2);
  endtask

  task automatic pulse_iack();
    k.irq_ack = 1'b1; cyc(1); k.irq_ack = 1'b0; cyc(2);
  endtask

  task automatic do_reset();
    reset = 1'b1; cyc(2); reset = 1'b0; cyc(1);
  endtask

  // Byte-level reference model.
  logic       m_e0, m_f0, m_lsh, m_rsh, m_down, m_ar2, m_ready, m_ovr, m_irq, m_mask;
  int         m_skip;
  logic [8:0] m_held;
  logic [6:0] m_code;

  task automatic m_reset();
    m_e0 = 0; m_f0 = 0; m_lsh = 0; m_rsh = 0; m_down = 0; m_ar2 = 0;
    m_ready = 0; m_ovr = 0; m_irq = 0; m_skip = 0; m_held = '0; m_code = '0;
  endtask

  task automatic m_make(input logic e, input logic [7:0] b);
    logic [7:0] r;
    if (!e && b == 8'h12) m_lsh = 1;
    else if (!e && b == 8'h59) m_rsh = 1;
    else if (!(e && b == 8'h12)) begin
      if (REPEAT_FILTER && m_down && m_held == {e, b}) return;
      r = xlate(b, e, m_lsh | m_rsh);
      if (r[6:0] == 7'd0) return;
      m_down = 1; m_held = {e, b};
      if (!m_ready) begin
        m_code = r[6:0]; m_ar2 = r[7]; m_ready = 1;
        if (!m_mask) m_irq = 1;
      end else begin
        m_ovr = 1;
      end
    end
  endtask

  task automatic m_brk(input logic e, input logic [7:0] b);
    if (!e && b == 8'h12) m_lsh = 0;
    else if (!e && b == 8'h59) m_rsh = 0;
    else if (m_held == {e, b}) m_down = 0;
  endtask

  task automatic m_byte(input logic [7:0] b);
    if (m_skip > 0) begin m_skip--; return; end
    if (m_f0) begin m_brk(m_e0, b); m_f0 = 0; m_e0 = 0; return; end
    if (m_e0) begin
      if (b == 8'hF0) m_f0 = 1;
      else if (b != 8'hE0) begin m_e0 = 0; m_make(1'b1, b); end
      return;
    end
    if (b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'hFF}) return;
    if (b == 8'hE0) m_e0 = 1;
    else if (b == 8'hF0) m_f0 = 1;
    else if (b == 8'hE1) m_skip = 7;
    else m_make(1'b0, b);
  endtask

  logic [7:0] pool [12] = '{8'h1C, 8'h32, 8'h16, 8'h12, 8'h59, 8'hE0,
                            8'hF0, 8'hF0, 8'h71, 8'hAA, 8'h00, 8'hE1};

  initial begin
    reset = 1'b1;
    k.ps2_data = '0; k.ps2_stb = 0; k.rd_ack = 0; k.irq_mask = 0; k.irq_ack = 0;

    //  op  data   code   ar2 rdy dn ovr irq sh
    add(0, 8'h1C, 7'h61, 0, 1, 1, 0, 1, 0);
    add(0, 8'hF0, 7'h61, 0, 1, 1, 0, 1, 0);
    add(0, 8'h1C, 7'h61, 0, 1, 0, 0, 1, 0);
    add(1, 8'h00, 7'h61, 0, 0, 0, 0, 0, 0);
    add(0, 8'h12, 7'h61, 0, 0, 0, 0, 0, 1);
    add(0, 8'h1C, 7'h41, 0, 1, 1, 0, 1, 1);
    add(0, 8'hF0, 7'h41, 0, 1, 1, 0, 1, 1);
    add(0, 8'h1C, 7'h41, 0, 1, 0, 0, 1, 1);
    add(0, 8'hF0, 7'h41, 0, 1, 0, 0, 1, 1);
    add(0, 8'h12, 7'h41, 0, 1, 0, 0, 1, 0);
    add(1, 8'h00, 7'h41, 0, 0, 0, 0, 0, 0);
    add(0, 8'h1C, 7'h61, 0, 1, 1, 0, 1, 0);
    add(1, 8'h00, 7'h61, 0, 0, 1, 0, 0, 0);
    add(0, 8'hE0, 7'h61, 0, 0, 1, 0, 0, 0);
    add(0, 8'h71, 7'o031, 1, 1, 1, 0, 1, 0);
    add(2, 8'h00, 7'o031, 1, 1, 1, 0, 0, 0);
    add(1, 8'h00, 7'o031, 1, 0, 1, 0, 0, 0);
    add(0, 8'h1C, 7'h61, 0, 1, 1, 0, 1, 0);
    add(0, 8'h32, 7'h61, 0, 1, 1, 1, 1, 0);
    add(1, 8'h00, 7'h61, 0, 0, 1, 0, 0, 0);
    add(0, 8'hE1, 7'h61, 0, 0, 1, 0, 0, 0);
    add(0, 8'h14, 7'h61, 0, 0, 1, 0, 0, 0);
    add(0, 8'h77, 7'h61, 0, 0, 1, 0, 0, 0);
    add(0, 8'hE1, 7'h61, 0, 0, 1, 0, 0, 0);
    add(0, 8'hF0, 7'h61, 0, 0, 1, 0, 0, 0);
    add(0, 8'h14, 7'h61, 0, 0, 1, 0, 0, 0);
    add(0, 8'hF0, 7'h61, 0, 0, 1, 0, 0, 0);
    add(0, 8'h77, 7'h61, 0, 0, 1, 0, 0, 0);
    add(0, 8'h1C, 7'h61, 0, 1, 1, 0, 1, 0);
    add(0, 8'h1C, 7'h61, 0, 1, 1, !REPEAT_FILTER, 1, 0);

    cyc(3);
    chk_state("reset", 7'h00, 0, 0, 0, 0, 0, 0);
    chk("reset tr_code", 32'(k.tr_code), 32'h0);
    chk("reset tr_e0", 32'(k.tr_e0), 32'h0);
    reset = 1'b0;
    cyc(1);

    for (int i = 0; i < tv.size(); i++) begin
      case (tv[i].op)
        0: send(tv[i].data);
        1: pulse_rd();
        default: pulse_iack();
      endcase
      chk_state($sformatf("tv%0d", i), tv[i].code, tv[i].ar2, tv[i].ready,
                tv[i].down, tv[i].ovr, tv[i].irq, tv[i].shift);
    end

    // Make latency: translator inputs at N+1, latched key at N+2.
    do_reset();
    k.ps2_data = 8'h1C; k.ps2_stb = 1'b1;
    cyc(1);
    k.ps2_stb = 1'b0;
    chk("lat n1 tr_code", 32'(k.tr_code), 32'h1C);
    chk("lat n1 tr_e0", 32'(k.tr_e0), 32'h0);
    chk("lat n1 key_ready", 32'(k.key_ready), 32'h0);
    cyc(1);
    chk("lat n2 key_ready", 32'(k.key_ready), 32'h1);
    chk("lat n2 key_code", 32'(k.key_code), 32'h61);
    chk("lat n2 irq_req", 32'(k.irq_req), 32'h1);
    cyc(2);

    // rd_ack in the lookup cycle: new key latched, no overrun.
    k.ps2_data = 8'h32; k.ps2_stb = 1'b1;
    cyc(1);
    k.ps2_stb = 1'b0; k.rd_ack = 1'b1;
    cyc(1);
    k.rd_ack = 1'b0;
    chk("rdlat key_code", 32'(k.key_code), 32'h62);
    chk("rdlat key_ready", 32'(k.key_ready), 32'h1);
    chk("rdlat overrun", 32'(k.overrun), 32'h0);
    chk("rdlat irq_req", 32'(k.irq_req), 32'h1);
    cyc(2);

    // Strobe during S_LOOKUP is not lost.
    pulse_rd();
    k.ps2_data = 8'h1C; k.ps2_stb = 1'b1;
    cyc(1);
    k.ps2_data = 8'h32;
    cyc(1);
    k.ps2_stb = 1'b0;
    chk("b2b first key_code", 32'(k.key_code), 32'h61);
    chk("b2b first overrun", 32'(k.overrun), 32'h0);
    cyc(1);
    chk("b2b second overrun", 32'(k.overrun), 32'h1);
    chk("b2b second key_code", 32'(k.key_code), 32'h61);
    cyc(2);

    // Masked latch, then unmask: no request raised.
    pulse_rd();
    k.irq_mask = 1'b1;
    cyc(1);
    send(8'h1C);
    chk("mask key_ready", 32'(k.key_ready), 32'h1);
    chk("mask irq_req", 32'(k.irq_req), 32'h0);
    k.irq_mask = 1'b0;
    cyc(2);
    chk("unmask irq_req", 32'(k.irq_req), 32'h0);

    // Reset in the middle of an E0 sequence.
    send(8'hE0);
    do_reset();
    chk_state("midrst", 7'h00, 0, 0, 0, 0, 0, 0);
    chk("midrst tr_code", 32'(k.tr_code), 32'h0);
    send(8'h1C);
    chk_state("midrst make", 7'h61, 0, 1, 1, 0, 1, 0);

    // Random traffic against the model.
    do_reset();
    m_reset();
    m_mask = 0;
    for (int n = 0; n < 400; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 70) begin
        logic [7:0] b;
        b = pool[$urandom_range(0, 11)];
        m_byte(b);
        send(b);
      end else if (r < 80) begin
        m_ready = 0; m_ovr = 0; m_irq = 0;
        pulse_rd();
      end else if (r < 88) begin
        m_irq = 0;
        pulse_iack();
      end else begin
        k.irq_mask = ~k.irq_mask;
        m_mask = k.irq_mask;
        if (m_mask) m_irq = 0;
        cyc(2);
      end
      chk_state($sformatf("rnd%0d", n), m_code, m_ar2, m_ready, m_down, m_ovr, m_irq, m_lsh | m_rsh);
    end
    k.irq_mask = 1'b0;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
